dmem_lsu_ctrl: RTL and testbench

Load/store sequencer between the pipeline MEM stage and the word-wide, word-addressed data memory. The data memory has a synchronous write, an asynchronous read and no byte enables.
This block provides byte, halfword and word loads with sign or zero extension. Byte and halfword stores are done as read-modify-write.
It owns the memory's we/addr/din lines and presents a valid/ready request and one-cycle response pulse to the pipeline.

---
 rtl/dmem_lsu_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a word-wide data memory.
// Sub-word stores are done as read-modify-write over an ACCESS/WRITE pair.
module dmem_lsu_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE
    } state_t;

    state_t                  state, state_next;
    logic                    we_r;
    logic [1:0]              size_r;
    logic                    uns_r;
    logic [1:0]              boff_r;
    logic [ADDR_WIDTH-1:0]   waddr_r;
    logic [31:0]             wdata_r;
    logic [31:0]             merge_r;

    logic                    accept;
    logic                    err;
    logic                    subword_store;
    logic [7:0]              lane_b;
    logic [15:0]             lane_h;
    logic [31:0]             load_data;
    logic [31:0]             merge_data;
    logic                    unused_addr_bits;

    // Address bits above the memory depth are dropped, so accesses wrap.
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign mem_addr  = waddr_r;

    always_comb begin
        case (size_r)
            2'b00:   err = 1'b0;
            2'b01:   err = boff_r[0];
            2'b10:   err = |boff_r;
            default: err = 1'b1;
        endcase
    end

    assign subword_store = we_r && !err && (size_r != 2'b10);

    assign lane_b = mem_dout[{boff_r, 3'b000} +: 8];
    assign lane_h = boff_r[1] ? mem_dout[31:16] : mem_dout[15:0];

    always_comb begin
        case (size_r)
            2'b00:   load_data = {{24{~uns_r & lane_b[7]}}, lane_b};
            2'b01:   load_data = {{16{~uns_r & lane_h[15]}}, lane_h};
            default: load_data = mem_dout;
        endcase
    end

    always_comb begin
        merge_data = mem_dout;
        if (size_r == 2'b00) begin
            merge_data[{boff_r, 3'b000} +: 8] = wdata_r[7:0];
        end else if (boff_r[1]) begin
            merge_data[31:16] = wdata_r[15:0];
        end else begin
            merge_data[15:0] = wdata_r[15:0];
        end
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_din    = wdata_r;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_ACCESS;
            end
            S_ACCESS: begin
                state_next = subword_store ? S_WRITE : S_IDLE;
                mem_we     = we_r && !err && (size_r == 2'b10);
            end
            S_WRITE: begin
                state_next = S_IDLE;
                mem_we     = 1'b1;
                mem_din    = merge_r;
            end
            default: state_next = S_IDLE;
        endcase
        // Reset kills any write in flight, including a pending RMW commit.
        if (rst) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            we_r      <= 1'b0;
            size_r    <= '0;
            uns_r     <= 1'b0;
            boff_r    <= '0;
            waddr_r   <= '0;
            wdata_r   <= '0;
            merge_r   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= 1'b0;
            if (accept) begin
                we_r    <= req_we;
                size_r  <= req_size;
                uns_r   <= req_unsigned;
                boff_r  <= req_addr[1:0];
                waddr_r <= req_addr[ADDR_WIDTH+1:2];
                wdata_r <= req_wdata;
            end
            case (state)
                S_ACCESS: begin
                    if (subword_store) begin
                        merge_r <= merge_data;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || we_r) ? '0 : load_data;
                    end
                end
                S_WRITE: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed steps plus randomized
// requests against a word-array reference model.
module tb_dmem_lsu_ctrl;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    logic [31:0]   tbmem   [DEPTH];
    logic [31:0]   ref_mem [DEPTH];
    logic          preload;

    int checks   = 0;
    int failures = 0;

    dmem_lsu_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Attached data memory: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (preload) tbmem <= ref_mem;
        else if (mem_we) tbmem[mem_addr] <= mem_din;
    end
    assign mem_dout = tbmem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    function automatic logic is_err(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic uns, input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (size == 2'd0) return (!uns && b >= 128) ? b + 32'hFFFFFF00 : b;
        if (size == 2'd1) return (!uns && h >= 32768) ? h + 32'hFFFF0000 : h;
        return w;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] off, input logic [31:0] d);
        logic [31:0] m;
        if (size == 2'd2) return d;
        if (size == 2'd0) m = 32'hFF << (8 * off);
        else              m = 32'hFFFF << (16 * (off / 2));
        return (w & ~m) | ((d << ((size == 2'd0) ? 8 * off : 16 * (off / 2))) & m);
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
        int          wi, lat, nwe, exp_lat, exp_nwe;
        logic        e;
        logic [31:0] oldw, exp_rdata, newv;
        wi   = widx(addr);
        e    = is_err(size, addr[1:0]);
        oldw = ref_mem[wi];
        exp_rdata = (e || we) ? 32'h0 : ref_load(oldw, size, uns, addr[1:0]);
        newv      = (we && !e) ? ref_store(oldw, size, addr[1:0], wdata) : oldw;
        exp_nwe   = (we && !e) ? 1 : 0;
        exp_lat   = (we && !e && size != 2'd2) ? 3 : 2;

        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_we = 1'($urandom); req_size = 2'($urandom);

        lat = 0; nwe = 0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_we) begin
                nwe++;
                check({tag, "_waddr"}, 32'(mem_addr), 32'(wi));
                check({tag, "_wdata"}, mem_din, newv);
            end
            if (rsp_valid) lat = c;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_nwrites"}, 32'(nwe), 32'(exp_nwe));
        check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e});
        if (!we || e) check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        rdata = rsp_rdata;
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
        ref_mem[wi] = newv;
        check({tag, "_mem"}, tbmem[wi], ref_mem[wi]);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_exp  [4];
        int          idx, mism;

        rst = 1'b1; preload = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Word store / load round trip
        do_req("sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, rd);
        do_req("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd);
        check("lw40_const", rd, 32'hDEADBEEF);

        // Byte RMW
        do_req("sw40b", 1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, rd);
        do_req("sb41", 1'b1, 2'd0, 1'b0, 32'h41, 32'h000000AA, rd);
        do_req("lw40c", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd);
        check("lw40c_const", rd, 32'h1122AA44);

        // Sign / zero extension
        do_req("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, rd);
        do_req("lb12", 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, rd);
        check("lb12_const", rd, 32'hFFFFFFFF);
        do_req("lbu12", 1'b0, 2'd0, 1'b1, 32'h12, 32'h0, rd);
        check("lbu12_const", rd, 32'h000000FF);
        do_req("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd);
        check("lh12_const", rd, 32'hFFFF80FF);
        do_req("lhu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd);
        check("lhu12_const", rd, 32'h000080FF);
        do_req("lb10", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, rd);
        check("lb10_const", rd, 32'h00000001);

        // Error cases
        do_req("sh43", 1'b1, 2'd1, 1'b0, 32'h43, 32'h12345678, rd);
        do_req("lw42", 1'b0, 2'd2, 1'b0, 32'h42, 32'h0, rd);
        do_req("sz11", 1'b1, 2'd3, 1'b0, 32'h40, 32'hCAFEF00D, rd);
        check("err_mem40", tbmem[16], 32'h1122AA44);

        // Reset during the WRITE cycle of a sub-word store
        do_req("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h55667788, rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_access_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_write_we", {31'b0, mem_we}, 32'd0);
        check("abort_ready_rst", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", {31'b0, req_ready}, 32'd1);
        check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        check("abort_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("abort_rsp_rdata", rsp_rdata, 32'd0);
        check("abort_mem", tbmem[8], 32'h55667788);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_rsp_late", {31'b0, rsp_valid}, 32'd0);
        end

        // Back-to-back word loads with req_valid held high
        b2b_addr[0] = 32'h40; b2b_addr[1] = 32'h10; b2b_addr[2] = 32'h20; b2b_addr[3] = 32'h44;
        for (int i = 0; i < 4; i++) b2b_exp[i] = ref_mem[widx(b2b_addr[i])];
        idx = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = b2b_addr[0];
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            check("b2b_ready", {31'b0, req_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check("b2b_rsp_valid", {31'b0, rsp_valid}, (c >= 2 && c % 2 == 0) ? 32'd1 : 32'd0);
            if (c >= 2 && c % 2 == 0) check("b2b_rdata", rsp_rdata, b2b_exp[c / 2 - 1]);
            if (c % 2 == 0) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx < 4) req_addr = b2b_addr[idx];
                else req_valid = 1'b0;
            end
        end

        // Randomized traffic, full 32-bit addresses exercise wrap-around
        for (int n = 0; n < 200; n++) begin
            logic        rwe, runs;
            logic [1:0]  rsz;
            logic [31:0] ra;
            rwe  = 1'($urandom);
            runs = 1'($urandom);
            rsz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'd2) ra[1:0] = 2'b00;
                if (rsz == 2'd1) ra[0] = 1'b0;
            end
            do_req("rnd", rwe, rsz, runs, ra, $urandom, rd);
        end

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (tbmem[i] !== ref_mem[i]) mism++;
        check("final_mem_mismatches", 32'(mism), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
